// File: rtl/rotate_sequencer.sv
// rotate_sequencer: rotates a 4x4 byte matrix by quarter-turns, one turn per cycle.
// Define ROTATE_SEQ_STATS_EN to add the blk_count output-handshake counter.
module rotate_sequencer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic [1:0]   in_count,
    input  logic         in_dir,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
`ifdef ROTATE_SEQ_STATS_EN
    ,
    output logic [15:0]  blk_count
`endif
);
    typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

    state_t       state, state_nxt;
    logic [127:0] mat;
    logic [1:0]   rem;
    logic         dir;

    // Byte (r,c) lives at bits [127-8*(4r+c) -: 8]
    function automatic logic [127:0] quarter(input logic [127:0] m, input logic ccw);
        logic [127:0] q;
        q = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                q[127-8*(4*i+j) -: 8] = ccw ? m[127-8*(4*j+3-i) -: 8] : m[127-8*(4*(3-j)+i) -: 8];
        return q;
    endfunction

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        out_block = mat;
        case (state)
            IDLE:    if (in_valid) state_nxt = (in_count != 2'd0) ? ROTATE : DONE;
            ROTATE:  if (rem == 2'd1) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mat   <= '0;
            rem   <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                mat <= in_block;
                rem <= in_count;
                dir <= in_dir;
            end else if (state == ROTATE) begin
                mat <= quarter(mat, dir);
                rem <= rem - 2'd1;
            end
        end
    end

`ifdef ROTATE_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blk_count <= '0;
        else if (state == DONE && out_ready) blk_count <= blk_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_rotate_sequencer.sv
// tb_rotate_sequencer: randomized checks of rotate_sequencer against a 2D-array rotation model.
module tb_rotate_sequencer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_block = '0;
    logic [1:0]   in_count = '0;
    logic         in_dir = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_block;
    logic         busy;
`ifdef ROTATE_SEQ_STATS_EN
    logic [15:0]  blk_count;
`endif
    int checks = 0;
    int errors = 0;
    int handshakes = 0;
    localparam logic [127:0] SEQ = 128'h000102030405060708090A0B0C0D0E0F;

    rotate_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .in_count(in_count), .in_dir(in_dir),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy)
`ifdef ROTATE_SEQ_STATS_EN
        , .blk_count(blk_count)
`endif
    );

    always #5 clk = ~clk;

    // Net clockwise turns on a 2D array: a left turn is three right turns
    function automatic logic [127:0] model(input logic [127:0] b, input int cnt, input bit ccw);
        logic [7:0] m [4][4];
        logic [7:0] n [4][4];
        logic [127:0] o;
        int turns;
        turns = ccw ? (4 - cnt) % 4 : cnt;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) m[r][c] = b[127-8*(4*r+c) -: 8];
        for (int t = 0; t < turns; t++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) n[r][c] = m[3-c][r];
            m = n;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) o[127-8*(4*r+c) -: 8] = m[r][c];
        return o;
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run(input logic [127:0] b, input logic [1:0] cnt, input logic d,
                       output logic [127:0] res, output int lat, output logic post_idle);
        in_block = b; in_count = cnt; in_dir = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_block;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        handshakes++;
        post_idle = !out_valid && in_ready && !busy;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_block !== '0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b out_block=%h, want 1 0 0 0",
                     in_ready, out_valid, busy, out_block);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [127:0] res;
        int lat;
        logic pi;
        run(SEQ, 2'd1, 1'b0, res, lat, pi);
        checks++;
        if (res[127:96] !== 32'h0C080400 || lat !== 2) begin
            errors++;
            $display("FAIL cw1: row0=%h lat=%0d, want 0c080400 lat=2", res[127:96], lat);
        end
        run(SEQ, 2'd1, 1'b1, res, lat, pi);
        checks++;
        if (res[127:96] !== 32'h03070B0F || res[31:0] !== 32'h0004080C || lat !== 2) begin
            errors++;
            $display("FAIL ccw1: row0=%h row3=%h lat=%0d, want 03070b0f 0004080c lat=2",
                     res[127:96], res[31:0], lat);
        end
        for (int d = 0; d < 2; d++) begin
            run(SEQ, 2'd2, d[0], res, lat, pi);
            checks++;
            if (res[127:96] !== 32'h0F0E0D0C || lat !== 3) begin
                errors++;
                $display("FAIL cnt2 dir%0d: row0=%h lat=%0d, want 0f0e0d0c lat=3", d, res[127:96], lat);
            end
        end
        run(SEQ, 2'd0, 1'b1, res, lat, pi);
        checks++;
        if (res !== SEQ || lat !== 1 || pi !== 1'b1) begin
            errors++;
            $display("FAIL cnt0: out=%h lat=%0d idle=%b, want %h lat=1 idle=1", res, lat, pi, SEQ);
        end
    endtask

    task automatic test_random();
        logic [127:0] b, res, exp;
        logic [1:0] cnt;
        logic d;
        int lat;
        logic pi;
        for (int i = 0; i < 24; i++) begin
            b = rand_block();
            cnt = 2'($urandom_range(0, 3));
            d = 1'($urandom_range(0, 1));
            exp = model(b, cnt, d);
            run(b, cnt, d, res, lat, pi);
            checks++;
            if (res !== exp || lat !== 1 + int'(cnt) || pi !== 1'b1) begin
                errors++;
                $display("FAIL random%0d cnt=%0d dir=%b: out=%h lat=%0d idle=%b, want %h lat=%0d idle=1",
                         i, cnt, d, res, lat, pi, exp, 1 + int'(cnt));
            end
        end
        run(SEQ, 2'd3, 1'b0, res, lat, pi);
        exp = res;
        run(SEQ, 2'd1, 1'b1, res, lat, pi);
        checks++;
        if (res !== exp || lat !== 2) begin
            errors++;
            $display("FAIL cw3_vs_ccw1: ccw1=%h lat=%0d, want %h lat=2", res, lat, exp);
        end
`ifdef ROTATE_SEQ_STATS_EN
        checks++;
        if (blk_count !== 16'(handshakes)) begin
            errors++;
            $display("FAIL blk_count: got %0d want %0d", blk_count, handshakes);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b, held;
        logic [1:0] cnt;
        int lat;
        a = rand_block();
        b = ~a;
        cnt = 2'($urandom_range(0, 3));
        in_block = a; in_count = cnt; in_dir = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_block = b; in_count = 2'd2; in_dir = 1'b1;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        held = out_block;
        checks++;
        if (held !== model(a, cnt, 1'b0) || lat !== 1 + int'(cnt)) begin
            errors++;
            $display("FAIL bp_first: out=%h lat=%0d, want %h lat=%0d", held, lat, model(a, cnt, 1'b0), 1 + int'(cnt));
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_block !== held || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b out=%h, want 1 0 %h",
                         i, out_valid, in_ready, out_block, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        handshakes++;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b busy=%b in_ready=%b, want 0 0 1", out_valid, busy, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (out_block !== model(b, 2, 1'b1) || lat !== 3) begin
            errors++;
            $display("FAIL bp_pending: out=%h lat=%0d, want %h lat=3", out_block, lat, model(b, 2, 1'b1));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        handshakes++;
    endtask

    task automatic test_reset_mid();
        logic [127:0] b, res, exp;
        int lat;
        logic pi;
        bit seen = 0;
        b = rand_block();
        in_block = b; in_count = 2'd3; in_dir = 1'b0; in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_block !== '0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b out_valid=%b in_ready=%b out=%h, want 0 0 1 0",
                     busy, out_valid, in_ready, out_block);
        end
        #1 rst_n = 1'b1;
        handshakes = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        out_ready = 1'b0;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_reset_discard: out_valid seen=1, want 0");
        end
        b = rand_block();
        exp = model(b, 3, 1'b1);
        run(b, 2'd3, 1'b1, res, lat, pi);
        checks++;
        if (res !== exp || lat !== 4) begin
            errors++;
            $display("FAIL after_reset: out=%h lat=%0d, want %h lat=4", res, lat, exp);
        end
`ifdef ROTATE_SEQ_STATS_EN
        checks++;
        if (blk_count !== 16'd1) begin
            errors++;
            $display("FAIL blk_count_after_reset: got %0d want 1", blk_count);
        end
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
